// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide scheduler: op encoding, FSM states, default width.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_sched_hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hi_we,
  input  logic [WIDTH-1:0] i_hi_d,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_lo_d,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_hi_d;
      if (i_lo_we) r_lo <= i_lo_d;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_sched.sv
// Sequences the external multiplier/divider, stalls execute while busy and
// commits HI/LO once per instruction; flush and watchdog abort without side effects.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   src_a_i,
  input  logic [WIDTH-1:0]   src_b_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               mul_start_o,
  output logic               mul_signed_o,
  output logic               div_start_o,
  output logic               div_signed_o,
  output logic [WIDTH-1:0]   opa_o,
  output logic [WIDTH-1:0]   opb_o,
  input  logic               mul_ready_i,
  input  logic [2*WIDTH-1:0] mul_result_i,
  input  logic               div_ready_i,
  input  logic [2*WIDTH-1:0] div_result_i,
  output logic               unit_flush_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               timeout_o
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [RES_W-1:0]   r_result;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_signed;

  op_e                w_op;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_mt;
  logic               w_accept;
  logic               w_waiting;
  logic               w_ready;
  logic               w_timeout;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_hi_we;
  logic               w_lo_we;
  logic [WIDTH-1:0]   w_hi_d;
  logic [WIDTH-1:0]   w_lo_d;

  assign w_op      = op_e'(op_i);
  assign w_is_mul  = op_valid_i && (w_op == OP_MULT || w_op == OP_MULTU);
  assign w_is_div  = op_valid_i && (w_op == OP_DIV  || w_op == OP_DIVU);
  assign w_is_mt   = op_valid_i && (w_op == OP_MTHI || w_op == OP_MTLO);
  assign w_accept  = (r_state == ST_IDLE) && (w_is_mul || w_is_div) && !flush_i;
  assign w_waiting = (r_state == ST_MUL_WAIT) || (r_state == ST_DIV_WAIT);
  assign w_ready   = ((r_state == ST_MUL_WAIT) && mul_ready_i) ||
                     ((r_state == ST_DIV_WAIT) && div_ready_i);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Ready in the final wait cycle wins over the watchdog.
  assign w_timeout = w_waiting && !w_ready && !flush_i && (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) w_state_next = w_is_mul ? ST_MUL_WAIT : ST_DIV_WAIT;
        end
        ST_MUL_WAIT, ST_DIV_WAIT: begin
          if (w_ready)        w_state_next = ST_DONE;
          else if (w_timeout) w_state_next = ST_IDLE;
        end
        ST_DONE: begin
          if (!stall_i) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs and HI/LO write controls
  always_comb begin
    busy_o       = 1'b0;
    mul_start_o  = 1'b0;
    mul_signed_o = 1'b0;
    div_start_o  = 1'b0;
    div_signed_o = 1'b0;
    unit_flush_o = flush_i || w_timeout;
    timeout_o    = w_timeout;
    w_hi_we      = 1'b0;
    w_lo_we      = 1'b0;
    w_hi_d       = src_a_i;
    w_lo_d       = src_a_i;
    case (r_state)
      ST_IDLE: begin
        busy_o  = w_accept;
        w_hi_we = w_is_mt && (w_op == OP_MTHI) && !stall_i && !flush_i;
        w_lo_we = w_is_mt && (w_op == OP_MTLO) && !stall_i && !flush_i;
      end
      ST_MUL_WAIT: begin
        busy_o       = !flush_i;
        mul_start_o  = 1'b1;
        mul_signed_o = r_signed;
      end
      ST_DIV_WAIT: begin
        busy_o       = !flush_i;
        div_start_o  = 1'b1;
        div_signed_o = r_signed;
      end
      ST_DONE: begin
        w_hi_we = !stall_i && !flush_i;
        w_lo_we = !stall_i && !flush_i;
        w_hi_d  = r_result[RES_W-1:WIDTH];
        w_lo_d  = r_result[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Operand latches, watchdog counter and result capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_opa    <= src_a_i;
        r_opb    <= src_b_i;
        r_signed <= (w_op == OP_MULT) || (w_op == OP_DIV);
        r_cnt    <= '0;
      end else if (w_waiting && !w_ready) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_ready && !flush_i) begin
        r_result <= (r_state == ST_MUL_WAIT) ? mul_result_i : div_result_i;
      end
    end
  end

  assign opa_o = r_opa;
  assign opb_o = r_opb;

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk     (clk),
    .rst     (rst),
    .i_hi_we (w_hi_we),
    .i_hi_d  (w_hi_d),
    .i_lo_we (w_lo_we),
    .i_lo_d  (w_lo_d),
    .o_hi    (hi_o),
    .o_lo    (lo_o)
  );

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: mul/div sequencing, stall hold, flush, MTxx, watchdog, reset.
module tb_muldiv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i, src_b_i;
  logic        stall_i, flush_i;
  logic        busy_o, mul_start_o, mul_signed_o, div_start_o, div_signed_o;
  logic [31:0] opa_o, opb_o;
  logic        mul_ready_i, div_ready_i;
  logic [63:0] mul_result_i, div_result_i;
  logic        unit_flush_o, timeout_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  muldiv_sched #(.WIDTH(32), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .stall_i(stall_i), .flush_i(flush_i),
    .busy_o(busy_o), .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .opa_o(opa_o), .opb_o(opb_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .unit_flush_o(unit_flush_o), .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0; op_valid_i = 1'b0; op_i = 3'd0; src_a_i = '0; src_b_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; mul_ready_i = 1'b0; div_ready_i = 1'b0;
    mul_result_i = 64'h1111_2222_3333_4444; div_result_i = 64'h5555_6666_7777_8888;
    tick(); tick(); settle();
    check("rst_hi", 64'(hi_o), 64'h0);
    check("rst_lo", 64'(lo_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_starts", 64'({mul_start_o, div_start_o, mul_signed_o, div_signed_o}), 64'h0);
    check("rst_flush_to", 64'({unit_flush_o, timeout_o}), 64'h0);
    check("rst_opab", {opa_o, opb_o}, 64'h0);
    rst = 1'b1;
    tick();

    // MULT -2 * 3, ready in 4th wait cycle
    op_valid_i = 1'b1; op_i = 3'd1; src_a_i = 32'hFFFF_FFFE; src_b_i = 32'd3;
    settle();
    check("mult_accept_busy", 64'(busy_o), 64'h1);
    cnt = busy_o ? 1 : 0;
    tick();
    op_valid_i = 1'b0; src_a_i = '0; src_b_i = '0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        mul_ready_i = 1'b1; mul_result_i = 64'hFFFF_FFFF_FFFF_FFFA;
      end
      settle();
      if (busy_o) cnt++;
      if (i == 1) begin
        check("mult_start", 64'({mul_start_o, div_start_o}), 64'h2);
        check("mult_signed", 64'(mul_signed_o), 64'h1);
        check("mult_opab", {opa_o, opb_o}, 64'hFFFF_FFFE_0000_0003);
      end
      if (i == 4) check("mult_start_in_ready", 64'(mul_start_o), 64'h1);
      tick();
    end
    mul_ready_i = 1'b0; mul_result_i = 64'h0;
    settle();
    if (busy_o) cnt++;
    check("mult_busy_cycles", 64'(cnt), 64'd5);
    check("mult_done_no_early_hi", 64'(hi_o), 64'h0);
    tick(); settle();
    check("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_idle_busy", 64'(busy_o), 64'h0);

    // DIVU 100/7 with 3 stall cycles after ready
    op_valid_i = 1'b1; op_i = 3'd4; src_a_i = 32'd100; src_b_i = 32'd7;
    tick();
    op_valid_i = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      if (i == 5) begin
        mul_ready_i = 1'b1; mul_result_i = 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        mul_ready_i = 1'b0;
      end
      if (i == 33) begin
        div_ready_i = 1'b1; div_result_i = 64'h0000_0002_0000_000E;
      end
      settle();
      if (i == 1) begin
        check("divu_start", 64'({mul_start_o, div_start_o, div_signed_o}), 64'h2);
        check("divu_busy", 64'(busy_o), 64'h1);
      end
      if (i == 6) check("divu_ignore_mul_ready", 64'(div_start_o), 64'h1);
      tick();
    end
    div_ready_i = 1'b0; div_result_i = 64'hDEAD_DEAD_DEAD_DEAD; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("divu_stall_hold", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
      check("divu_done_busy", 64'(busy_o), 64'h0);
      tick();
    end
    stall_i = 1'b0;
    tick(); settle();
    check("divu_hilo", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
    tick(); tick(); settle();
    check("divu_single_write", {hi_o, lo_o}, 64'h0000_0002_0000_000E);

    // DIV flushed at wait cycle 10
    op_valid_i = 1'b1; op_i = 3'd3; src_a_i = 32'd50; src_b_i = 32'd5;
    tick();
    op_valid_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) flush_i = 1'b1;
      settle();
      if (i == 1) check("div_signed", 64'(div_signed_o), 64'h1);
      if (i == 10) begin
        check("flush_unit_flush", 64'(unit_flush_o), 64'h1);
        check("flush_busy", 64'(busy_o), 64'h0);
      end
      tick();
    end
    flush_i = 1'b0;
    settle();
    check("flush_pulse_end", 64'(unit_flush_o), 64'h0);
    check("flush_idle", 64'({busy_o, div_start_o}), 64'h0);
    check("flush_hilo", {hi_o, lo_o}, 64'h0000_0002_0000_000E);

    // MTHI / MTLO back to back, then stalled MTLO
    op_valid_i = 1'b1; op_i = 3'd5; src_a_i = 32'hDEAD_BEEF;
    settle();
    check("mthi_busy", 64'(busy_o), 64'h0);
    tick();
    op_i = 3'd6; src_a_i = 32'h1234_5678;
    settle();
    check("mtlo_busy", 64'(busy_o), 64'h0);
    check("mthi_hi", {hi_o, lo_o}, 64'hDEAD_BEEF_0000_000E);
    tick();
    op_i = 3'd6; src_a_i = 32'hCAFE_F00D; stall_i = 1'b1;
    settle();
    check("mt_hilo", {hi_o, lo_o}, 64'hDEAD_BEEF_1234_5678);
    tick(); tick(); settle();
    check("mtlo_stall_hold", 64'(lo_o), 64'h1234_5678);
    stall_i = 1'b0;
    tick();
    op_valid_i = 1'b0;
    settle();
    check("mtlo_after_stall", {hi_o, lo_o}, 64'hDEAD_BEEF_CAFE_F00D);

    // MULTU with no ready: watchdog on 64th wait cycle
    op_valid_i = 1'b1; op_i = 3'd2; src_a_i = 32'd9; src_b_i = 32'd9;
    tick();
    op_valid_i = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 63; i++) begin
      settle();
      if (timeout_o || unit_flush_o) cnt++;
      tick();
    end
    check("to_no_early_pulse", 64'(cnt), 64'd0);
    settle();
    check("to_pulse", 64'({timeout_o, unit_flush_o, mul_start_o, mul_signed_o}), 64'hE);
    tick(); settle();
    check("to_after", 64'({timeout_o, unit_flush_o, busy_o, mul_start_o}), 64'h0);
    check("to_hilo", {hi_o, lo_o}, 64'hDEAD_BEEF_CAFE_F00D);

    // Reset during DIV_WAIT with HI=5
    op_valid_i = 1'b1; op_i = 3'd5; src_a_i = 32'd5;
    tick();
    op_i = 3'd3; src_a_i = 32'd40; src_b_i = 32'd6;
    tick();
    op_valid_i = 1'b0; src_a_i = '0; src_b_i = '0;
    settle();
    check("rst2_pre_hi", 64'(hi_o), 64'h5);
    check("rst2_pre_wait", 64'(div_start_o), 64'h1);
    rst = 1'b0;
    tick(); settle();
    check("rst2_hilo", {hi_o, lo_o}, 64'h0);
    check("rst2_ctrl", 64'({busy_o, mul_start_o, mul_signed_o, div_start_o, div_signed_o,
                             unit_flush_o, timeout_o}), 64'h0);
    check("rst2_opab", {opa_o, opb_o}, 64'h0);
    rst = 1'b1;
    tick(); settle();
    check("rst2_stay_idle", 64'({busy_o, div_start_o}), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
Controller that sequences the external multi-cycle multiplier and divider for MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers. It sits beside the execute-stage ALU. It accepts one op per execute-stage instruction and drives the unit start/ready handshakes. It stalls the pipeline while a unit is busy, holds the result while the pipeline is stalled elsewhere, and commits HI/LO exactly once per instruction. MTHI/MTLO write HI/LO directly. Flush aborts any in-flight operation with no architectural effect.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH, unit results are 2*WIDTH.
TIMEOUT_CYC, 64, max cycles waiting for unit ready before abort; counter is $clog2(TIMEOUT_CYC+1) bits.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
op_valid_i  in  1  execute-stage instruction carries an op below
op_i  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
src_a_i  in  WIDTH  rs value (dividend / MTxx source)
src_b_i  in  WIDTH  rt value (divisor)
stall_i  in  1  execute stage held by another cause
flush_i  in  1  execute stage flushed this cycle
busy_o  out  1  stall request to hazard unit
mul_start_o  out  1  level start to multiplier
mul_signed_o  out  1  1 = signed
div_start_o  out  1  level start to divider
div_signed_o  out  1  1 = signed
opa_o, opb_o  out  WIDTH each  latched operands to both units
mul_ready_i  in  1  multiplier result valid
mul_result_i  in  2*WIDTH  {hi, lo}
div_ready_i  in  1  divider result valid
div_result_i  in  2*WIDTH  {remainder, quotient}
unit_flush_o  out  1  abort pulse to both units
hi_o, lo_o  out  WIDTH each  architectural HI/LO
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst=0 at an edge): state IDLE; HI, LO, result register, operand latches and counter all 0. Every output is 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE, op_valid_i and op is MULT/MULTU/DIV/DIVU and flush_i=0:
  - busy_o=1 combinationally in this accept cycle, regardless of stall_i.
  - Latch src_a/src_b into opa/opb and the signedness bit.
  - Next state MUL_WAIT or DIV_WAIT; counter clears.
- MUL_WAIT / DIV_WAIT:
  - busy_o=1; the matching start_o=1 and its signed_o is valid; the other start_o=0.
  - On the matching ready_i=1: capture the result into the result register and go to DONE. start_o stays high in the ready cycle (unit contract).
  - The counter increments each waiting cycle. On reaching TIMEOUT_CYC: pulse timeout_o and unit_flush_o, go to IDLE, no HI/LO write.
- DONE:
  - busy_o=0.
  - If stall_i=0, write HI/LO from the result register at this edge and go to IDLE.
  - If stall_i=1, hold DONE with the result unchanged and no write.
  - Latency: ready at cycle N gives HI/LO visible at N+2 at the earliest.
- MTHI/MTLO in IDLE with op_valid_i=1, stall_i=0, flush_i=0: HI (or LO) = src_a_i at this edge. busy_o=0. The other register is untouched.
- Flush, highest priority in any state:
  - unit_flush_o=1 that cycle; next state IDLE.
  - No HI/LO write, even in DONE with stall_i=0; result discarded.
  - busy_o=0 in the flush cycle.
- No re-accept: DONE returns to IDLE only after commit. The instruction has then left execute, so IDLE never re-issues the same op.
- DIV with divisor 0: no special case; the unit result is committed as-is.
- hi_o/lo_o always reflect the registers. There is no bypass of a same-cycle write.
- Ready from the non-selected unit is ignored.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding enum (3-bit);
  - state enum;
  - WIDTH default.
- One natural sub-module: hilo_reg. It is the two WIDTH registers with independent write enables and synchronous active-low reset; it is also reused by the later forwarding logic.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3; mul_ready after 4 cycles -> busy_o high for 5 cycles, mul_signed_o=1; HI=0xFFFFFFFF, LO=0xFFFFFFFA 2 cycles after ready.
- DIVU a=100, b=7, div_ready after 33 cycles, stall_i=1 for 3 cycles after ready -> state holds DONE with no write; then HI=2, LO=14 on the first edge with stall_i=0; exactly one write.
- DIV issued, flush_i at wait cycle 10 -> unit_flush_o one pulse, IDLE next cycle, HI/LO unchanged, busy_o=0 in flush cycle.
- MTHI 0xDEADBEEF then MTLO 0x12345678 back-to-back -> HI=0xDEADBEEF, LO=0x12345678, busy_o never asserted; MTLO with stall_i=1 -> no write until stall drops.
- MULTU with mul_ready never asserted, TIMEOUT_CYC=64 -> timeout_o and unit_flush_o pulse on the 64th wait cycle, IDLE after, HI/LO unchanged.
- rst=0 asserted during DIV_WAIT with HI=5 -> next edge: state IDLE, HI=LO=0, all outputs 0.
